// File: rtl/btb_maintenance_controller.sv
// BTB write-port owner: invalidation sweep (reset/flush) arbitrated against buffered branch updates.
// Latency: accepted update written 1 cycle later when idle; sweep clears one index per cycle.
// Backpressure: upd_ready low when the update FIFO is full, during flush_req, or in reset.
// Optional feature: BTB_SWEEP_ON_RESET_EN selects a post-reset invalidation sweep.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push && !clr) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
endmodule

module btb_maintenance_controller #(
  parameter int XLEN           = 32,
  parameter int BTB_INDEX_BITS = 8,
  parameter int UPD_FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush_req,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [XLEN-1:0]           upd_pc,
  input  logic [XLEN-1:0]           upd_target,
  input  logic                      upd_taken,
  output logic                      btb_wr_en,
  output logic                      btb_wr_clear,
  output logic [BTB_INDEX_BITS-1:0] btb_wr_index,
  output logic [XLEN-1:0]           btb_wr_pc,
  output logic [XLEN-1:0]           btb_wr_target,
  output logic                      btb_wr_taken,
  output logic                      flush_busy,
  output logic                      predict_en
);
  typedef enum logic {IDLE, SWEEP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } upd_t;

`ifdef BTB_SWEEP_ON_RESET_EN
  localparam state_t RESET_STATE = SWEEP;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  localparam logic [BTB_INDEX_BITS-1:0] LAST_IDX = '1;

  state_t                    state;
  logic [BTB_INDEX_BITS-1:0] sweep_idx;
  upd_t                      upd_in;
  upd_t                      fifo_head;
  upd_t                      wr_upd;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      upd_fire;
  logic                      wr_upd_vld;

  assign upd_in    = '{pc: upd_pc, target: upd_target, taken: upd_taken};
  assign upd_ready = !fifo_full && !flush_req && reset_n;
  assign upd_fire  = upd_valid && upd_ready;

  // Queued updates always go before new arrivals; an empty FIFO in IDLE is bypassed.
  assign fifo_pop   = (state == IDLE) && !flush_req && !fifo_empty;
  assign fifo_push  = upd_fire && ((state == SWEEP) || !fifo_empty);
  assign wr_upd_vld = fifo_pop || ((state == IDLE) && upd_fire && fifo_empty);
  assign wr_upd     = fifo_pop ? fifo_head : upd_in;

  sync_fifo #(
    .W     ($bits(upd_t)),
    .DEPTH (UPD_FIFO_DEPTH)
  ) u_upd_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (flush_req),
    .push     (fifo_push),
    .push_dat (upd_in),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // sweep_idx holds the next index to clear; a flush issues index 0 on the sampling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_STATE;
      sweep_idx     <= '0;
      btb_wr_en     <= 1'b0;
      btb_wr_clear  <= 1'b0;
      btb_wr_index  <= '0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
      btb_wr_taken  <= 1'b0;
      flush_busy    <= 1'b0;
    end else begin
      btb_wr_en     <= 1'b0;
      btb_wr_clear  <= 1'b0;
      btb_wr_index  <= '0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
      btb_wr_taken  <= 1'b0;
      flush_busy    <= 1'b0;
      if (flush_req) begin
        state        <= SWEEP;
        sweep_idx    <= BTB_INDEX_BITS'(1);
        btb_wr_en    <= 1'b1;
        btb_wr_clear <= 1'b1;
        flush_busy   <= 1'b1;
      end else if (state == SWEEP) begin
        sweep_idx    <= sweep_idx + BTB_INDEX_BITS'(1);
        btb_wr_en    <= 1'b1;
        btb_wr_clear <= 1'b1;
        btb_wr_index <= sweep_idx;
        flush_busy   <= 1'b1;
        if (sweep_idx == LAST_IDX) state <= IDLE;
      end else if (wr_upd_vld) begin
        btb_wr_en     <= 1'b1;
        btb_wr_index  <= wr_upd.pc[BTB_INDEX_BITS+1:2];
        btb_wr_pc     <= wr_upd.pc;
        btb_wr_target <= wr_upd.target;
        btb_wr_taken  <= wr_upd.taken;
      end
    end
  end

  // The state term keeps prediction off while held in reset with a pending reset sweep.
  assign predict_en = !flush_busy && (state != SWEEP);
endmodule

// File: tb/tb_btb_maintenance_controller.sv
// Scoreboard bench for btb_maintenance_controller: expected BTB writes (with their cycle) are
// queued when stimulus is driven and compared as the DUT issues them.
module tb_btb_maintenance_controller;
  localparam int XLEN  = 32;
  localparam int IB    = 8;
  localparam int DEPTH = 4;
  localparam int N     = 1 << IB;
`ifdef BTB_SWEEP_ON_RESET_EN
  localparam logic PRED_RST = 1'b0;
`else
  localparam logic PRED_RST = 1'b1;
`endif

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush_req = 1'b0;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0;
  logic [XLEN-1:0] upd_target = '0;
  logic            upd_taken = 1'b0;
  logic            upd_ready;
  logic            btb_wr_en;
  logic            btb_wr_clear;
  logic [IB-1:0]   btb_wr_index;
  logic [XLEN-1:0] btb_wr_pc;
  logic [XLEN-1:0] btb_wr_target;
  logic            btb_wr_taken;
  logic            flush_busy;
  logic            predict_en;

  btb_maintenance_controller #(
    .XLEN(XLEN), .BTB_INDEX_BITS(IB), .UPD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset_n(reset_n), .flush_req(flush_req),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken),
    .btb_wr_en(btb_wr_en), .btb_wr_clear(btb_wr_clear), .btb_wr_index(btb_wr_index),
    .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target), .btb_wr_taken(btb_wr_taken),
    .flush_busy(flush_busy), .predict_en(predict_en)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic            clr;
    logic [IB-1:0]   idx;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            tkn;
    int              at;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  // Write monitor: every DUT write must match the head of the expected queue, cycle included.
  always @(negedge clock) begin
    if (reset_n && btb_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(btb_wr_en), 64'(0));
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_clear",  64'(btb_wr_clear),  64'(e.clr));
        check("wr_index",  64'(btb_wr_index),  64'(e.idx));
        check("wr_pc",     64'(btb_wr_pc),     64'(e.pc));
        check("wr_target", 64'(btb_wr_target), 64'(e.tgt));
        check("wr_taken",  64'(btb_wr_taken),  64'(e.tkn));
        check("wr_cycle",  64'(cyc),           64'(e.at));
        check("wr_busy",   64'(flush_busy),    64'(e.clr));
        check("wr_pred",   64'(predict_en),    64'(!e.clr));
      end
    end
  end

  task automatic push_clears(input int k0, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e = '{clr: 1'b1, idx: IB'(i), pc: '0, tgt: '0, tkn: 1'b0, at: k0 + i};
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; k0 is the posedge that samples flush_req.
  task automatic flush_pulse(output int k0);
    flush_req = 1'b1;
    k0 = cyc + 1;
    @(negedge clock);
    flush_req = 1'b0;
  endtask

  // at_mode: -1 write expected the cycle after accept, -2 never written, else explicit cycle.
  task automatic send_upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                          input logic tkn, input int at_mode, output int acc);
    int n;
    wr_t e;
    n = 0;
    acc = -1;
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_target = tgt;
    upd_taken = tkn;
    #1;
    while (!upd_ready && n < 600) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!upd_ready) begin
      check("upd_ready_timeout", 64'(upd_ready), 64'(1));
    end else begin
      acc = cyc + 1;
      if (at_mode != -2) begin
        e = '{clr: 1'b0, idx: pc[IB+1:2], pc: pc, tgt: tgt, tkn: tkn,
              at: (at_mode == -1) ? acc : at_mode};
        exp_q.push_back(e);
      end
    end
    @(negedge clock);
    upd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},     64'(btb_wr_en),     64'(0));
    check({tag, "_clear"},  64'(btb_wr_clear),  64'(0));
    check({tag, "_index"},  64'(btb_wr_index),  64'(0));
    check({tag, "_pc"},     64'(btb_wr_pc),     64'(0));
    check({tag, "_target"}, 64'(btb_wr_target), 64'(0));
    check({tag, "_taken"},  64'(btb_wr_taken),  64'(0));
    check({tag, "_busy"},   64'(flush_busy),    64'(0));
    check({tag, "_pred"},   64'(predict_en),    64'(PRED_RST));
    check({tag, "_ready"},  64'(upd_ready),     64'(0));
  endtask

  initial begin
    int k0;
    int k1;
    int acc;
    logic [XLEN-1:0] pcs [5];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10c; pcs[4] = 32'h3f0;

    // Reset values, then optional post-reset sweep.
    #2;
    check_reset_outputs("rst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
`ifdef BTB_SWEEP_ON_RESET_EN
    push_clears(cyc + 1, N);
`endif
    wait_drain(N + 50);
    @(negedge clock);
    #1;
    check("post_rst_busy", 64'(flush_busy), 64'(0));
    check("post_rst_pred", 64'(predict_en), 64'(1));
    check("post_rst_ready", 64'(upd_ready), 64'(1));

    // IDLE update: index from pc[9:2], written the cycle after acceptance.
    @(negedge clock);
    send_upd(32'h0000_1040, 32'h0000_2000, 1'b1, -1, acc);
    send_upd(32'h0000_0ffc, 32'h0000_0040, 1'b0, -1, acc);
    wait_drain(20);

    // Flush from IDLE with three updates buffered and drained right after index 255.
    @(negedge clock);
    push_clears(cyc + 1, N);
    flush_pulse(k0);
    for (int j = 0; j < 3; j++) begin
      send_upd(pcs[j], 32'h500 + 32'(j), 1'(j), k0 + N + j, acc);
      check("sweep_acc_cycle", 64'(acc), 64'(k0 + 1 + j));
    end
    wait_drain(N + 50);

    // Five updates during a sweep: fifth held off until the drain frees a slot.
    @(negedge clock);
    push_clears(cyc + 1, N);
    flush_pulse(k0);
    for (int j = 0; j < 4; j++) begin
      send_upd(pcs[j], 32'ha00 + 32'(j), 1'b1, k0 + N + j, acc);
      check("full_acc_cycle", 64'(acc), 64'(k0 + 1 + j));
    end
    #1;
    check("full_ready_low", 64'(upd_ready), 64'(0));
    send_upd(pcs[4], 32'hbeef, 1'b0, k0 + N + 4, acc);
    check("fifth_acc_cycle", 64'(acc), 64'(k0 + N + 1));
    wait_drain(N + 50);

    // Flush restart at index 100; buffered updates are discarded.
    @(negedge clock);
    push_clears(cyc + 1, 101);
    flush_pulse(k0);
    send_upd(32'h200, 32'h1, 1'b1, -2, acc);
    send_upd(32'h204, 32'h2, 1'b1, -2, acc);
    while (cyc < k0 + 100) @(negedge clock);
    push_clears(cyc + 1, N);
    flush_req = 1'b1;
    upd_valid = 1'b1;
    upd_pc = 32'h208;
    #1;
    check("ready_during_flush", 64'(upd_ready), 64'(0));
    @(negedge clock);
    flush_req = 1'b0;
    upd_valid = 1'b0;
    wait_drain(N + 150);
    repeat (8) @(negedge clock);

    // Reset pulse mid-drain with two entries still queued.
    push_clears(cyc + 1, N);
    flush_pulse(k0);
    for (int j = 0; j < 3; j++) send_upd(pcs[j], 32'hc00 + 32'(j), 1'b1, k0 + N + j, acc);
    while (cyc < k0 + N) @(negedge clock);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
`ifdef BTB_SWEEP_ON_RESET_EN
    push_clears(cyc + 1, N);
`endif
    wait_drain(N + 50);
    repeat (10) @(negedge clock);
    #1;
    check("final_en", 64'(btb_wr_en), 64'(0));
    check("final_busy", 64'(flush_busy), 64'(0));
    check("final_pred", 64'(predict_en), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btb_maintenance_controller.md
# btb_maintenance_controller

Owns the branch predictor's BTB write port and arbitrates it between execute-stage branch-outcome updates and an invalidation sweep. The sweep clears every BTB entry, one per cycle, after reset and on a flush request such as fence.i. Updates that arrive during a sweep are buffered in a small FIFO and drained in order afterwards. The block sits between the execute stage and the branch predictor, and drives the predictor's write inputs plus a prediction-enable gate.

## Interface
- XLEN, 32, address/data width
- BTB_INDEX_BITS, 8, BTB index width; entry count = 2^BTB_INDEX_BITS
- UPD_FIFO_DEPTH, 4, update buffer depth (power of two, ≥2)

Ports:
- clock  in  1  sole clock; all state changes on posedge
- reset_n  in  1  asynchronous, active-low reset
- flush_req  in  1  single-cycle request to invalidate the whole BTB
- upd_valid  in  1  execute stage presents a resolved branch
- upd_ready  out  1  update accepted on a posedge where upd_valid && upd_ready
- upd_pc  in  XLEN  PC of the resolved branch
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  resolved direction
- btb_wr_en  out  1  write BTB this cycle
- btb_wr_clear  out  1  1 = write an invalid entry (sweep); 0 = normal history update
- btb_wr_index  out  BTB_INDEX_BITS  entry index
- btb_wr_pc  out  XLEN  branch PC, for tag and index derivation
- btb_wr_target  out  XLEN  target
- btb_wr_taken  out  1  direction
- flush_busy  out  1  sweep in progress
- predict_en  out  1  = !flush_busy; gates predicted_jump_target_taken

## Operation
- States:
  - IDLE: no sweep in progress.
  - SWEEP: invalidation sweep in progress; the index counter `sweep_idx` runs 0..2^BTB_INDEX_BITS−1.
- IDLE to SWEEP: flush_req is sampled high. sweep_idx is cleared to 0 and the FIFO is emptied, discarding stale updates.
- SWEEP to IDLE: after the write for the last index is issued.
- flush_req high while in SWEEP: sweep_idx restarts at 0 and the FIFO is emptied.
- SWEEP writes: each cycle, btb_wr_en=1, btb_wr_clear=1, btb_wr_index=sweep_idx. btb_wr_pc, btb_wr_target and btb_wr_taken are 0.
- Update index: upd_pc[BTB_INDEX_BITS+1:2]. The low two PC bits are ignored.
- Update path in IDLE:
  - An accepted update is written through the output registers on the next cycle, with btb_wr_clear=0.
  - If the FIFO is non-empty, its head is written first and new arrivals are appended, preserving order.
  - One write is issued per cycle.
- Update path in SWEEP: accepted updates are queued and drained one per cycle, in order, starting the cycle after the sweep ends.
- upd_ready = !fifo_full && !flush_req && reset_n. An update presented in the same cycle as flush_req is not accepted.
- Sweep writes always win the write port. No update write is issued while flush_busy=1.

## Timing
- All btb_wr_* outputs and flush_busy are registered. Reset value of every output is 0, except predict_en=1 when the macro is off.
- predict_en is derived from flush_busy and follows it in the same cycle.
- Update latency: accept at posedge E leads to btb_wr_en in the cycle following E, when in IDLE with an empty FIFO.
- Sweep timing:
  - flush_req is sampled at posedge E0. The index-0 clear is visible in the cycle after E0, and index i in the i-th cycle after that.
  - flush_busy is high exactly during the 2^BTB_INDEX_BITS clear cycles, then low.
- Reset asserted mid-sweep or mid-drain: the FIFO is emptied, all outputs go to their reset values, and sweep_idx is set to 0.
- FIFO full: upd_ready drops in the same cycle that the count reaches UPD_FIFO_DEPTH.

## Configuration
- BTB_SWEEP_ON_RESET_EN defined:
  - The reset state is SWEEP with sweep_idx=0.
  - The first posedge after reset_n rises issues the index-0 clear. flush_busy=1 and predict_en=0 through the full sweep.
  - Required on FPGA/ASIC, where BTB RAM contents are undefined at power-up.
- Undefined: the reset state is IDLE. This is for simulation with a zero-initialised BTB. Sweeps occur only on flush_req.

## Test plan
- Reset, macro on → after release, 256 consecutive writes with btb_wr_clear=1 at indices 0..255; flush_busy and predict_en=0 throughout; flush_busy=0 in cycle 257.
- IDLE update: upd_pc=0x0000_1040, upd_target=0x0000_2000, upd_taken=1 → next cycle btb_wr_en=1, btb_wr_index=0x10, btb_wr_clear=0, btb_wr_target=0x0000_2000, btb_wr_taken=1.
- flush_req in IDLE, then 3 updates with pc 0x100/0x104/0x108 during the sweep → all accepted; writes to indices 0x40/0x41/0x42, in order, in the three cycles immediately after the index-255 clear.
- 5 updates presented during a sweep with depth 4 → the first 4 are accepted; upd_ready=0 for the 5th until the drain begins; no update write occurs before the sweep ends.
- flush_req asserted when sweep_idx=100 → the next clear is at index 0; 101+256 total clear writes; queued updates are discarded.
- reset_n pulsed low mid-drain with 2 entries queued → no queued update is ever written; sweep from index 0 (macro on) or IDLE with all outputs 0 (macro off).
